// File: rtl/uart_tx_cfg.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_cfg
// Description : UART transmitter with a small TX FIFO. The bit period, parity
//               mode and stop-bit count are chosen at run time. Frames go out
//               back-to-back while the FIFO holds data.
// Ports       : i_clk     - clock
//               i_rst     - synchronous active-high reset
//               i_valid   - push request (data on i_data)
//               i_data    - word to transmit, sent LSB first
//               o_ready   - FIFO can accept a word this cycle
//               i_div     - clocks per bit (values below 2 act as 2)
//               i_parity  - 00/11 none, 01 odd, 10 even
//               i_stop2   - 1 selects two stop bits
//               o_tx      - serial line, registered, idle high
//               o_busy    - frame in progress or FIFO non-empty
//               o_level   - FIFO occupancy (word in flight not counted)
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_cfg #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_W      = 16,
    parameter int CYCLES_BIT = 217
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_valid,
    input  logic [DATA_BITS-1:0]          i_data,
    output logic                          o_ready,
    input  logic [DIV_W-1:0]              i_div,
    input  logic [1:0]                    i_parity,
    input  logic                          i_stop2,
    output logic                          o_tx,
    output logic                          o_busy,
    output logic [$clog2(FIFO_DEPTH):0]   o_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int BW = $clog2(DATA_BITS);

    // Elaboration-time guard on the parameter ranges the design supports.
    generate
        if (DATA_BITS < 5 || DATA_BITS > 9 || FIFO_DEPTH < 2 ||
            (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || CYCLES_BIT < 2) begin : g_bad_param
            $error("uart_tx_cfg: unsupported parameter value");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // ------------------------------------------------------------------------
    // FIFO storage and pointers
    // ------------------------------------------------------------------------
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_q;
    logic [AW-1:0]        rd_ptr_q;
    logic [LW-1:0]        level_q;

    logic                 w_ready;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_nempty;
    logic [DATA_BITS-1:0] w_head;

    // Ready depends only on the registered level, so a pop in the same
    // cycle never opens a slot early and there is no path from i_valid.
    assign w_ready  = (level_q != LW'(FIFO_DEPTH));
    assign w_push   = i_valid & w_ready;
    assign w_nempty = (level_q != '0);
    assign w_head   = mem_q[rd_ptr_q];

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= i_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Transmit FSM
    // ------------------------------------------------------------------------
    state_t               state_q,    state_d;
    logic [DIV_W-1:0]     cnt_q,      cnt_d;
    logic [BW-1:0]        bit_q,      bit_d;
    logic [DATA_BITS-1:0] shift_q,    shift_d;
    logic [DIV_W-1:0]     div_q,      div_d;
    logic                 par_en_q,   par_en_d;
    logic                 par_bit_q,  par_bit_d;
    logic                 stop2_q,    stop2_d;
    logic                 stop_2nd_q, stop_2nd_d;
    logic                 tx_q,       tx_d;

    logic                 w_bit_end;
    logic [DIV_W-1:0]     w_cnt_next;
    logic [DIV_W-1:0]     w_div_clamp;

    // Counter runs 0..div-1; with div >= 2 the terminal value never wraps.
    assign w_bit_end   = (cnt_q == div_q - 1'b1);
    assign w_cnt_next  = w_bit_end ? '0 : cnt_q + 1'b1;
    assign w_div_clamp = (i_div < DIV_W'(2)) ? DIV_W'(2) : i_div;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        div_d      = div_q;
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;
        stop2_d    = stop2_q;
        stop_2nd_d = stop_2nd_q;
        tx_d       = tx_q;
        w_pop      = 1'b0;

        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (w_nempty) begin
                    w_pop = 1'b1;
                end
            end
            S_START: begin
                cnt_d = w_cnt_next;
                if (w_bit_end) begin
                    state_d = S_DATA;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                end
            end
            S_DATA: begin
                cnt_d = w_cnt_next;
                if (w_bit_end) begin
                    if (bit_q == BW'(DATA_BITS - 1)) begin
                        if (par_en_q) begin
                            state_d = S_PARITY;
                            tx_d    = par_bit_q;
                        end else begin
                            state_d    = S_STOP;
                            stop_2nd_d = 1'b0;
                            tx_d       = 1'b1;
                        end
                    end else begin
                        shift_d = shift_q >> 1;
                        bit_d   = bit_q + 1'b1;
                        tx_d    = shift_q[1];
                    end
                end
            end
            S_PARITY: begin
                cnt_d = w_cnt_next;
                if (w_bit_end) begin
                    state_d    = S_STOP;
                    stop_2nd_d = 1'b0;
                    tx_d       = 1'b1;
                end
            end
            S_STOP: begin
                cnt_d = w_cnt_next;
                if (w_bit_end) begin
                    if (stop2_q && !stop_2nd_q) begin
                        stop_2nd_d = 1'b1;
                    end else if (w_nempty) begin
                        w_pop = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        tx_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase

        // A pop loads the next word and snapshots the line configuration,
        // so config changes mid-frame only affect later frames.
        if (w_pop) begin
            state_d    = S_START;
            cnt_d      = '0;
            shift_d    = w_head;
            div_d      = w_div_clamp;
            par_en_d   = ^i_parity;
            // Even parity is the XOR of the data; odd (01) inverts it.
            par_bit_d  = (^w_head) ^ i_parity[0];
            stop2_d    = i_stop2;
            stop_2nd_d = 1'b0;
            tx_d       = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            div_q      <= DIV_W'(2);
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            stop2_q    <= 1'b0;
            stop_2nd_q <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            div_q      <= div_d;
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
            stop2_q    <= stop2_d;
            stop_2nd_q <= stop_2nd_d;
            tx_q       <= tx_d;
        end
    end

    assign o_tx    = tx_q;
    assign o_ready = w_ready;
    assign o_busy  = (state_q != S_IDLE) || w_nempty;
    assign o_level = level_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_cfg.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_cfg
// Description : Directed self-checking bench for uart_tx_cfg (8 data bits,
//               4-entry FIFO). Outputs are sampled 1 ns after each rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_cfg;

    localparam int DB = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid;
    logic [7:0]  i_data;
    logic        o_ready;
    logic [15:0] i_div;
    logic [1:0]  i_parity;
    logic        i_stop2;
    logic        o_tx;
    logic        o_busy;
    logic [2:0]  o_level;

    int n_tests = 0;
    int n_fail  = 0;

    uart_tx_cfg #(
        .DATA_BITS  (8),
        .FIFO_DEPTH (4),
        .DIV_W      (16),
        .CYCLES_BIT (217)
    ) u_dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_valid  (i_valid),
        .i_data   (i_data),
        .o_ready  (o_ready),
        .i_div    (i_div),
        .i_parity (i_parity),
        .i_stop2  (i_stop2),
        .o_tx     (o_tx),
        .o_busy   (o_busy),
        .o_level  (o_level)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance until the start bit appears, at most max_cycles edges.
    task automatic wait_start(input string tag, input int max_cycles);
        int i;
        i = 0;
        while (o_tx !== 1'b0 && i < max_cycles) begin
            tick();
            i++;
        end
        check({tag, " start seen"}, o_tx, 0);
    endtask

    // Called right after the edge that drove the start bit. For each frame
    // bit, counts the cycles on which the line held the expected level.
    task automatic run_frame(input string tag, input logic [7:0] data, input int div,
                             input logic [1:0] par, input logic stop2);
        logic [15:0] exp_bits;
        int          n;
        int          good;
        n = 0;
        exp_bits = '0;
        exp_bits[n] = 1'b0; n++;
        for (int i = 0; i < DB; i++) begin
            exp_bits[n] = data[i]; n++;
        end
        if (par == 2'b10) begin
            exp_bits[n] = ^data; n++;
        end else if (par == 2'b01) begin
            exp_bits[n] = ~^data; n++;
        end
        exp_bits[n] = 1'b1; n++;
        if (stop2) begin
            exp_bits[n] = 1'b1; n++;
        end
        for (int b = 0; b < n; b++) begin
            good = 0;
            for (int c = 0; c < div; c++) begin
                if (o_tx === exp_bits[b]) good++;
                tick();
            end
            check($sformatf("%s bit%0d", tag, b), good, div);
        end
    endtask

    task automatic push_one(input logic [7:0] d);
        i_valid = 1'b1;
        i_data  = d;
        tick();
        i_valid = 1'b0;
    endtask

    logic [7:0] words [6];

    initial begin
        int good;
        int tries;
        logic r;

        rst      = 1'b1;
        i_valid  = 1'b0;
        i_data   = '0;
        i_div    = 16'd4;
        i_parity = 2'b00;
        i_stop2  = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // ---- reset state ----
        check("rst tx",    o_tx,    1);
        check("rst ready", o_ready, 1);
        check("rst busy",  o_busy,  0);
        check("rst level", o_level, 0);

        // ---- 8N1, div 4, 0x55, exact latency and frame length ----
        push_one(8'h55);
        check("t1 tx after push",    o_tx,    1);
        check("t1 level after push", o_level, 1);
        check("t1 busy after push",  o_busy,  1);
        tick();
        check("t1 tx low at pop",    o_tx,    0);
        check("t1 level after pop",  o_level, 0);
        run_frame("t1", 8'h55, 4, 2'b00, 1'b0);
        check("t1 busy end 40", o_busy, 0);
        check("t1 tx idle",     o_tx,   1);

        // ---- even parity on 0x07 -> parity bit 1 ----
        i_parity = 2'b10;
        push_one(8'h07);
        wait_start("t2e", 4);
        run_frame("t2e", 8'h07, 4, 2'b10, 1'b0);
        check("t2e busy", o_busy, 0);

        // ---- odd parity on 0x07 -> parity bit 0 ----
        i_parity = 2'b01;
        push_one(8'h07);
        wait_start("t2o", 4);
        run_frame("t2o", 8'h07, 4, 2'b01, 1'b0);

        // ---- two stop bits: line high 8 clocks ----
        i_parity = 2'b00;
        i_stop2  = 1'b1;
        push_one(8'hA3);
        wait_start("t2s", 4);
        run_frame("t2s", 8'hA3, 4, 2'b00, 1'b1);
        check("t2s busy", o_busy, 0);
        i_stop2 = 1'b0;

        // ---- FIFO fill, div 2, back-to-back frames ----
        i_div = 16'd2;
        words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h3C;
        words[3] = 8'h4B; words[4] = 8'h5A; words[5] = 8'h69;
        fork
            begin
                for (int w = 0; w < 6; w++) begin
                    i_valid = 1'b1;
                    i_data  = words[w];
                    tries   = 0;
                    do begin
                        r = o_ready;
                        tick();
                        tries++;
                    end while (!r && tries < 100);
                    if (w == 4) begin
                        check("t3 full level", o_level, 4);
                        check("t3 full ready", o_ready, 0);
                    end
                    if (w == 5) check("t3 stall tries", tries, 18);
                end
                i_valid = 1'b0;
            end
            begin
                wait_start("t3", 5);
                for (int f = 0; f < 6; f++) begin
                    run_frame($sformatf("t3 f%0d", f), words[f], 2, 2'b00, 1'b0);
                end
                check("t3 busy end",  o_busy,  0);
                check("t3 level end", o_level, 0);
            end
        join

        // ---- div change mid-frame ----
        i_div = 16'd4;
        i_valid = 1'b1;
        i_data  = 8'hC6;
        tick();
        i_data  = 8'h39;
        tick();
        i_valid = 1'b0;
        check("t4 start", o_tx, 0);
        fork
            run_frame("t4 f1", 8'hC6, 4, 2'b00, 1'b0);
            begin
                repeat (12) tick();
                i_div = 16'd8;
            end
        join
        run_frame("t4 f2", 8'h39, 8, 2'b00, 1'b0);
        check("t4 busy end", o_busy, 0);

        // ---- div 0 and 1 clamp to 2 ----
        i_div = 16'd0;
        push_one(8'h96);
        wait_start("t5 d0", 4);
        run_frame("t5 d0", 8'h96, 2, 2'b00, 1'b0);
        i_div = 16'd1;
        push_one(8'h2D);
        wait_start("t5 d1", 4);
        run_frame("t5 d1", 8'h2D, 2, 2'b00, 1'b0);
        check("t5 busy end", o_busy, 0);

        // ---- reset during DATA with 3 words queued ----
        i_div = 16'd4;
        i_valid = 1'b1;
        for (int w = 0; w < 4; w++) begin
            i_data = words[w];
            tick();
        end
        i_valid = 1'b0;
        check("t6 queued", o_level, 3);
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6 tx",    o_tx,    1);
        check("t6 level", o_level, 0);
        check("t6 busy",  o_busy,  0);
        check("t6 ready", o_ready, 1);
        good = 0;
        for (int c = 0; c < 60; c++) begin
            if (o_tx === 1'b1 && o_busy === 1'b0) good++;
            tick();
        end
        check("t6 silent after reset", good, 60);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
